// File: rtl/alu_issue.sv
// Issue stage in front of the combinational ALU: command FIFO, head presented
// to the ALU, result captured in a tagged valid/ready output register.
module alu_issue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [2:0]               alu_op,
    input  logic [31:0]              alu_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_c,
    output logic                     out_err,
    output logic [7:0]               out_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CAP  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CONE = 1;
    localparam logic [AW-1:0] PONE = 1;

    logic [2:0]    op_mem [DEPTH];
    logic [31:0]   a_mem  [DEPTH];
    logic [31:0]   b_mem  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    tag_cnt;
    logic          push;
    logic          pop;
    logic          illegal;

    assign in_ready = (count < CAP);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && (!out_valid || out_ready);

    assign alu_a   = a_mem[rd_ptr];
    assign alu_b   = b_mem[rd_ptr];
    assign alu_op  = op_mem[rd_ptr];
    // Ops 6 and 7 are the only encodings with both upper bits set
    assign illegal = alu_op[2] & alu_op[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem[i] <= '0;
                a_mem[i]  <= '0;
                b_mem[i]  <= '0;
            end
        end else if (push) begin
            op_mem[wr_ptr] <= in_op;
            a_mem[wr_ptr]  <= in_a;
            b_mem[wr_ptr]  <= in_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PONE;
            if (pop)
                rd_ptr <= rd_ptr + PONE;
            if (push && !pop)
                count <= count + CONE;
            else if (pop && !push)
                count <= count - CONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_err   <= 1'b0;
            out_tag   <= '0;
            tag_cnt   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_c     <= illegal ? 32'd0 : alu_c;
            out_err   <= illegal;
            out_tag   <= tag_cnt;
            tag_cnt   <= tag_cnt + 8'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU closing the loop.
module tb_alu_issue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_c;
    logic        out_err;
    logic [7:0]  out_tag;
    logic [2:0]  count;

    int checks;
    int failures;

    alu_issue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_err   (out_err),
        .out_tag   (out_tag),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Garbage on illegal ops so a DUT that forwards alu_c is caught
    always_comb begin
        alu_c = 32'hDEAD_BEEF;
        case (alu_op)
            3'd0: alu_c = alu_a + alu_b;
            3'd1: alu_c = alu_a - alu_b;
            3'd2: alu_c = alu_a & alu_b;
            3'd3: alu_c = alu_a | alu_b;
            3'd4: alu_c = alu_a >> alu_b[4:0];
            3'd5: alu_c = $signed(alu_a) >>> alu_b[4:0];
            default: alu_c = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  t_op  [6];
    logic [31:0] t_a   [6];
    logic [31:0] t_b   [6];
    logic [31:0] t_c   [6];
    logic        t_err [6];
    int          accepted;
    int          exp_tag;

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        check("rst_c", out_c, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single op latency
        drive(3'd0, 32'd1, 32'd1);
        check("single_cnt", 32'(count), 32'd1);
        check("single_nv", 32'(out_valid), 32'd0);
        idle();
        check("single_v", 32'(out_valid), 32'd1);
        check("single_c", out_c, 32'd2);
        check("single_tag", 32'(out_tag), 32'd0);
        check("single_err", 32'(out_err), 32'd0);

        // back-to-back
        drive(3'd1, 32'd1, 32'd1);
        drive(3'd2, 32'd1, 32'd3);
        check("b2b0_v", 32'(out_valid), 32'd1);
        check("b2b0_c", out_c, 32'd0);
        check("b2b0_tag", 32'(out_tag), 32'd1);
        idle();
        check("b2b1_v", 32'(out_valid), 32'd1);
        check("b2b1_c", out_c, 32'd1);
        check("b2b1_tag", 32'(out_tag), 32'd2);
        idle();
        check("b2b_drain", 32'(out_valid), 32'd0);
        check("b2b_hold", out_c, 32'd1);

        t_op[0] = 3'd3; t_a[0] = 32'd1;          t_b[0] = 32'd2;
        t_c[0] = 32'd3;          t_err[0] = 1'b0;
        t_op[1] = 3'd4; t_a[1] = 32'd5;          t_b[1] = 32'd2;
        t_c[1] = 32'd1;          t_err[1] = 1'b0;
        t_op[2] = 3'd5; t_a[2] = 32'h8000_0000;  t_b[2] = 32'd4;
        t_c[2] = 32'hF800_0000;  t_err[2] = 1'b0;
        t_op[3] = 3'd1; t_a[3] = 32'd0;          t_b[3] = 32'd1;
        t_c[3] = 32'hFFFF_FFFF;  t_err[3] = 1'b0;
        t_op[4] = 3'd6; t_a[4] = 32'd5;          t_b[4] = 32'd2;
        t_c[4] = 32'd0;          t_err[4] = 1'b1;
        t_op[5] = 3'd0; t_a[5] = 32'd7;          t_b[5] = 32'd8;
        t_c[5] = 32'd15;         t_err[5] = 1'b0;
        exp_tag = 3;
        for (int i = 0; i < 6; i++) begin
            drive(t_op[i], t_a[i], t_b[i]);
            idle();
            check($sformatf("vec%0d_v", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_c", i), out_c, t_c[i]);
            check($sformatf("vec%0d_err", i), 32'(out_err), 32'(t_err[i]));
            check($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(exp_tag));
            exp_tag++;
        end
        idle();

        // backpressure: six offered, five taken
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            if (in_ready)
                accepted++;
            drive(3'd0, 32'(i), 32'd100);
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_count", 32'(count), 32'd4);
        check("bp_ready", 32'(in_ready), 32'd0);
        check("bp_hold_c", out_c, 32'd100);
        check("bp_hold_tag", 32'(out_tag), 32'(exp_tag));
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            idle();
            check($sformatf("bp%0d_v", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_c", i), out_c, 32'(100 + i));
            check($sformatf("bp%0d_tag", i), 32'(out_tag), 32'(exp_tag + i));
            check($sformatf("bp%0d_cnt", i), 32'(count), 32'(4 - i));
            check($sformatf("bp%0d_rdy", i), 32'(in_ready), 32'd1);
        end
        idle();
        check("bp_empty", 32'(out_valid), 32'd0);

        // reset with work in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            drive(3'd0, 32'(i), 32'd1);
        in_valid = 1'b0;
        check("pre_rst_cnt", 32'(count), 32'd3);
        check("pre_rst_v", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;

        // 257 adds, tags wrap back to 0
        for (int i = 0; i < 257; i++) begin
            drive(3'd0, 32'(i), 32'd1);
            if (i >= 1) begin
                check($sformatf("wrap%0d_v", i - 1), 32'(out_valid), 32'd1);
                check($sformatf("wrap%0d_c", i - 1), out_c, 32'(i));
                check($sformatf("wrap%0d_tag", i - 1), 32'(out_tag),
                      32'((i - 1) % 256));
            end
        end
        idle();
        check("wrap_last_v", 32'(out_valid), 32'd1);
        check("wrap_last_c", out_c, 32'd257);
        check("wrap_last_tag", 32'(out_tag), 32'd0);
        idle();
        check("wrap_drain", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
